// File: rtl/vjtag_pkg.sv
// Shared types for the virtual-JTAG to SRAM bridge: command opcodes, FSM states
// and the frame-width helper.
package vjtag_pkg;

    typedef enum logic [1:0] {
        OpNop     = 2'b00,
        OpWrite   = 2'b01,
        OpRead    = 2'b10,
        OpSetAddr = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        StIdle,
        StWr,
        StRdWait,
        StRdDone
    } state_e;

    function automatic int unsigned frame_w(input int unsigned aw, input int unsigned dw);
        return 2 + aw + dw;
    endfunction

endpackage

// File: rtl/vjtag_sram_bridge_if.sv
// SRAM-side bus of the bridge: the bridge is the master, the memory the slave.
interface vjtag_sram_bridge_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
);
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;
    logic              sram_we;
    logic              sram_re;

    modport master (
        output sram_addr, sram_wdata, sram_we, sram_re,
        input  sram_rdata
    );

    modport slave (
        input  sram_addr, sram_wdata, sram_we, sram_re,
        output sram_rdata
    );
endinterface

// File: rtl/vjtag_sync.sv
// Multi-bit 2-flop synchroniser with a rising-edge detector on the synchronised value.
module vjtag_sync #(
    parameter int unsigned Width = 1
) (
    input  logic             clk,
    input  logic             aclr_n,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o,
    output logic [Width-1:0] rise_o
);
    logic [Width-1:0] meta_q, meta_d;
    logic [Width-1:0] sync_q, sync_d;
    logic [Width-1:0] prev_q, prev_d;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q_o    = sync_q;
    assign rise_o = sync_q & ~prev_q;
endmodule

// File: rtl/vjtag_sram_bridge.sv
// Virtual-JTAG frame shifter driving single-cycle SRAM reads/writes.
// Optional AUTO_INC_EN: address pointer loaded by SETADDR and post-incremented per access.
module vjtag_sram_bridge
    import vjtag_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                       clk,
    input  logic                       aclr_n,
    input  logic                       tck,
    input  logic                       tdi,
    input  logic                       v_sdr,
    input  logic                       udr,
    output logic                       tdo,
    vjtag_sram_bridge_if.master        sram,
    output logic                       busy,
    output logic                       cmd_drop
);
    localparam int unsigned FW   = frame_w(ADDR_W, DATA_W);
    localparam int unsigned CntW = $clog2(RD_LAT + 1);

    logic [3:0] sync_s, sync_rise;
    logic       tck_rise, tdi_s, v_sdr_s, udr_rise;
    logic       unused_sync;

    vjtag_sync #(.Width(4)) u_sync (
        .clk    (clk),
        .aclr_n (aclr_n),
        .d_i    ({tck, tdi, v_sdr, udr}),
        .q_o    (sync_s),
        .rise_o (sync_rise)
    );

    assign tck_rise    = sync_rise[3];
    assign tdi_s       = sync_s[2];
    assign v_sdr_s     = sync_s[1];
    assign udr_rise    = sync_rise[0];
    assign unused_sync = ^{sync_s[3], sync_s[0], sync_rise[2:1]};

    state_e            state_q, state_d;
    logic [FW-1:0]     frame_q, frame_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              we_q, we_d, re_q, re_d, busy_q, busy_d, drop_q, drop_d;
`ifdef AUTO_INC_EN
    logic [ADDR_W-1:0] ptr_q, ptr_d;
`endif

    opcode_e           op_f;
    logic [ADDR_W-1:0] addr_f, acc_addr;
    logic [DATA_W-1:0] data_f;

    assign op_f   = opcode_e'(frame_q[1:0]);
    assign data_f = frame_q[DATA_W+1:2];
    assign addr_f = frame_q[FW-1:DATA_W+2];
`ifdef AUTO_INC_EN
    assign acc_addr = ptr_q;
`else
    assign acc_addr = addr_f;
`endif

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        re_d    = 1'b0;
`ifdef AUTO_INC_EN
        ptr_d   = ptr_q;
`endif
        // Shifting is independent of the command FSM.
        if (tck_rise && v_sdr_s) begin
            frame_d = {tdi_s, frame_q[FW-1:1]};
        end
        unique case (state_q)
            StIdle: begin
                if (udr_rise) begin
                    case (op_f)
                        OpWrite: begin
                            state_d = StWr;
                            we_d    = 1'b1;
                            addr_d  = acc_addr;
                            wdata_d = data_f;
                        end
                        OpRead: begin
                            state_d = StRdWait;
                            re_d    = 1'b1;
                            addr_d  = acc_addr;
                            cnt_d   = '0;
                        end
`ifdef AUTO_INC_EN
                        OpSetAddr: ptr_d = addr_f;
`endif
                        default: ;
                    endcase
                end
            end
            StWr: begin
                state_d = StIdle;
`ifdef AUTO_INC_EN
                ptr_d   = ptr_q + 1'b1;
`endif
            end
            StRdWait: begin
`ifdef AUTO_INC_EN
                if (re_q) ptr_d = ptr_q + 1'b1;
`endif
                // cnt counts cycles since the strobe; data is valid after RD_LAT of them.
                if (cnt_q == CntW'(RD_LAT)) begin
                    rdata_d = sram.sram_rdata;
                    state_d = StRdDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRdDone: begin
                if (!v_sdr_s) begin
                    frame_d[DATA_W-1:0] = rdata_q;
                    state_d             = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        drop_d = udr_rise && (state_q != StIdle);
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q <= StIdle;
            frame_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
`ifdef AUTO_INC_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            re_q    <= re_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
`ifdef AUTO_INC_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign tdo             = frame_q[0];
    assign sram.sram_addr  = addr_q;
    assign sram.sram_wdata = wdata_q;
    assign sram.sram_we    = we_q;
    assign sram.sram_re    = re_q;
    assign busy            = busy_q;
    assign cmd_drop        = drop_q;
endmodule

// File: tb/tb_vjtag_sram_bridge.sv
// Directed bench: two bridges (RD_LAT 2 and 4) share the JTAG strobes and one SRAM model.
module tb_vjtag_sram_bridge;
    import vjtag_pkg::*;

    localparam int FW = 26;

    logic clk = 1'b0;
    logic aclr_n = 1'b0;
    logic tck = 1'b0, tdi = 1'b0, v_sdr = 1'b0, udr = 1'b0;
    logic tdo2, tdo4, busy2, busy4, drop2, drop4;

    always #5 clk = ~clk;

    vjtag_sram_bridge_if #(.ADDR_W(16), .DATA_W(8)) s2 ();
    vjtag_sram_bridge_if #(.ADDR_W(16), .DATA_W(8)) s4 ();

    vjtag_sram_bridge #(.ADDR_W(16), .DATA_W(8), .RD_LAT(2)) dut2 (
        .clk(clk), .aclr_n(aclr_n), .tck(tck), .tdi(tdi), .v_sdr(v_sdr), .udr(udr),
        .tdo(tdo2), .sram(s2.master), .busy(busy2), .cmd_drop(drop2)
    );
    vjtag_sram_bridge #(.ADDR_W(16), .DATA_W(8), .RD_LAT(4)) dut4 (
        .clk(clk), .aclr_n(aclr_n), .tck(tck), .tdi(tdi), .v_sdr(v_sdr), .udr(udr),
        .tdo(tdo4), .sram(s4.master), .busy(busy4), .cmd_drop(drop4)
    );

    // SRAM model: writes come from dut2 (dut4 issues identical ones); read pipes per latency.
    logic [7:0]  mem [0:65535];
    logic [7:0]  p2 [2];
    logic [7:0]  p4 [4];
    logic        pre_en = 1'b0;
    logic [15:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;

    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (s2.sram_we) mem[s2.sram_addr] <= s2.sram_wdata;
        p2[0] <= s2.sram_re ? mem[s2.sram_addr] : 8'h00;
        p2[1] <= p2[0];
        p4[0] <= s4.sram_re ? mem[s4.sram_addr] : 8'h00;
        for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
    end
    assign s2.sram_rdata = p2[1];
    assign s4.sram_rdata = p4[3];

    int we2_n = 0, re2_n = 0, we4_n = 0, re4_n = 0, busy2_n = 0, drop2_n = 0, drop4_n = 0;
    int both_n = 0;
    logic [15:0] last_waddr = '0, last_raddr = '0;
    logic [7:0]  last_wdata = '0;

    always @(negedge clk) begin
        if (s2.sram_we) begin
            we2_n      <= we2_n + 1;
            last_waddr <= s2.sram_addr;
            last_wdata <= s2.sram_wdata;
        end
        if (s2.sram_re) begin
            re2_n      <= re2_n + 1;
            last_raddr <= s2.sram_addr;
        end
        if (s4.sram_we) we4_n <= we4_n + 1;
        if (s4.sram_re) re4_n <= re4_n + 1;
        if (busy2) busy2_n <= busy2_n + 1;
        if (drop2) drop2_n <= drop2_n + 1;
        if (drop4) drop4_n <= drop4_n + 1;
        if ((s2.sram_we && s2.sram_re) || (s4.sram_we && s4.sram_re)) both_n <= both_n + 1;
    end

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk(input opcode_e op, input logic [15:0] a,
                                         input logic [7:0] d);
        return {a, d, op};
    endfunction

    // Shift a frame LSB first; tdo is captured before each tck rise.
    task automatic shift(input logic [FW-1:0] f, output logic [FW-1:0] c2,
                         output logic [FW-1:0] c4);
        v_sdr = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < FW; i++) begin
            tdi   = f[i];
            c2[i] = tdo2;
            c4[i] = tdo4;
            tck   = 1'b1;
            repeat (4) @(negedge clk);
            tck   = 1'b0;
            repeat (4) @(negedge clk);
        end
        v_sdr = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_udr();
        udr = 1'b1;
        @(negedge clk);
        udr = 1'b0;
        @(negedge clk);
    endtask

    task automatic send(input opcode_e op, input logic [15:0] a, input logic [7:0] d);
        logic [FW-1:0] c2, c4;
        shift(mk(op, a, d), c2, c4);
        pulse_udr();
        repeat (20) @(negedge clk);
    endtask

    // With the pointer build, aim the pointer at the frame address first.
    task automatic aim(input opcode_e op, input logic [15:0] a);
`ifdef AUTO_INC_EN
        if (op == OpWrite || op == OpRead) send(OpSetAddr, a, 8'h00);
`else
        if (op == OpSetAddr && a == 16'hxxxx) $display("unreachable");
`endif
    endtask

    task automatic readback(input string nm, input logic [7:0] exp);
        logic [FW-1:0] c2, c4;
        shift('0, c2, c4);
        chk({nm, "_tdo2"}, {24'h0, c2[7:0]}, {24'h0, exp});
        chk({nm, "_tdo4"}, {24'h0, c4[7:0]}, {24'h0, exp});
    endtask

    typedef struct {
        opcode_e     op;
        logic [15:0] addr;
        logic [7:0]  data;
        int          n_we;
        int          n_re;
        int          n_busy;
        logic [7:0]  rdata;
    } vec_t;

    task automatic apply(input vec_t v, input int idx);
        int w2, r2, w4, r4, b2;
        string nm;
        nm = $sformatf("v%0d", idx);
        aim(v.op, v.addr);
        w2 = we2_n; r2 = re2_n; w4 = we4_n; r4 = re4_n; b2 = busy2_n;
        send(v.op, v.addr, v.data);
        chk({nm, "_we2"}, we2_n - w2, v.n_we);
        chk({nm, "_re2"}, re2_n - r2, v.n_re);
        chk({nm, "_we4"}, we4_n - w4, v.n_we);
        chk({nm, "_re4"}, re4_n - r4, v.n_re);
        chk({nm, "_busycyc"}, busy2_n - b2, v.n_busy);
        chk({nm, "_idle"}, {30'h0, busy2, busy4}, 0);
        if (v.n_we != 0) begin
            chk({nm, "_waddr"}, last_waddr, v.addr);
            chk({nm, "_wdata"}, last_wdata, v.data);
        end
        if (v.n_re != 0) begin
            chk({nm, "_raddr"}, last_raddr, v.addr);
            readback(nm, v.rdata);
        end
    endtask

    vec_t vecs[9];

    initial begin
        int w2, r2, w4, r4, d2, d4;
        logic [FW-1:0] c2, c4;

        vecs[0] = '{OpWrite,   16'h1234, 8'hA5, 1, 0, 1, 8'h00};
        vecs[1] = '{OpRead,    16'h0010, 8'h00, 0, 1, 4, 8'h3C};
        vecs[2] = '{OpRead,    16'h1234, 8'h00, 0, 1, 4, 8'hA5};
        vecs[3] = '{OpNop,     16'h0000, 8'hFF, 0, 0, 0, 8'h00};
        vecs[4] = '{OpSetAddr, 16'h4321, 8'h77, 0, 0, 0, 8'h00};
        vecs[5] = '{OpWrite,   16'hFFFF, 8'h5A, 1, 0, 1, 8'h00};
        vecs[6] = '{OpRead,    16'hFFFF, 8'h00, 0, 1, 4, 8'h5A};
        vecs[7] = '{OpWrite,   16'h0000, 8'hC3, 1, 0, 1, 8'h00};
        vecs[8] = '{OpRead,    16'h0000, 8'h00, 0, 1, 4, 8'hC3};

        repeat (3) @(negedge clk);
        chk("rst_outs", {tdo2, s2.sram_we, s2.sram_re, busy2, drop2, s2.sram_wdata}, 0);
        chk("rst_addr", s2.sram_addr, 0);
        aclr_n = 1'b1;
        pre_addr = 16'h0010; pre_data = 8'h3C; pre_en = 1'b1;
        @(negedge clk);
        pre_en = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 9; i++) apply(vecs[i], i);

        // Read result is held while v_sdr stays high.
        aim(OpRead, 16'h0010);
        shift(mk(OpRead, 16'h0010, 8'h00), c2, c4);
        v_sdr = 1'b1;
        repeat (4) @(negedge clk);
        pulse_udr();
        repeat (20) @(negedge clk);
        chk("rddone_hold", {31'h0, busy2}, 1);
        v_sdr = 1'b0;
        repeat (10) @(negedge clk);
        chk("rddone_release", {31'h0, busy2}, 0);
        readback("rddone", 8'h3C);

        // Second udr while reading is dropped.
        aim(OpRead, 16'h1234);
        shift(mk(OpRead, 16'h1234, 8'h00), c2, c4);
        w2 = we2_n; r2 = re2_n; w4 = we4_n; r4 = re4_n; d2 = drop2_n; d4 = drop4_n;
        udr = 1'b1; @(negedge clk);
        udr = 1'b0; @(negedge clk);
        udr = 1'b1; @(negedge clk);
        udr = 1'b0;
        repeat (30) @(negedge clk);
        chk("drop4_cnt", drop4_n - d4, 1);
        chk("drop2_cnt", drop2_n - d2, 1);
        chk("drop4_re", re4_n - r4, 1);
        chk("drop4_we", we4_n - w4, 0);
        chk("drop2_re", re2_n - r2, 1);
        chk("drop2_we", we2_n - w2, 0);
        readback("drop", 8'hA5);

        // Reset in the middle of a read.
        aim(OpRead, 16'h0010);
        shift(mk(OpRead, 16'h0010, 8'h00), c2, c4);
        pulse_udr();
        for (int k = 0; k < 10 && !busy2; k++) @(negedge clk);
        chk("rst_pre_busy", {31'h0, busy2}, 1);
        @(negedge clk);
        aclr_n = 1'b0;
        #1;
        chk("rst_mid_ctl2", {tdo2, s2.sram_we, s2.sram_re, busy2, drop2}, 0);
        chk("rst_mid_bus2", {s2.sram_addr, s2.sram_wdata}, 0);
        chk("rst_mid_ctl4", {tdo4, s4.sram_we, s4.sram_re, busy4, drop4}, 0);
        chk("rst_mid_bus4", {s4.sram_addr, s4.sram_wdata}, 0);
        repeat (3) @(negedge clk);
        w2 = we2_n; r2 = re2_n; w4 = we4_n; r4 = re4_n;
        aclr_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("rst_no_strobe", (we2_n - w2) + (re2_n - r2) + (we4_n - w4) + (re4_n - r4), 0);
        apply('{OpWrite, 16'h0BEE, 8'h96, 1, 0, 1, 8'h00}, 20);
        apply('{OpRead, 16'h0BEE, 8'h00, 0, 1, 4, 8'h96}, 21);

`ifdef AUTO_INC_EN
        send(OpSetAddr, 16'hFFFF, 8'h00);
        send(OpWrite, 16'h0ABC, 8'h11);
        chk("ainc_addr0", last_waddr, 16'hFFFF);
        chk("ainc_data0", last_wdata, 8'h11);
        send(OpWrite, 16'h0ABC, 8'h22);
        chk("ainc_addr1", last_waddr, 16'h0000);
        chk("ainc_data1", last_wdata, 8'h22);
`endif

        chk("we_re_overlap", both_n, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vjtag_sram_bridge.md
VJTAG_SRAM_BRIDGE -- requirements
Module: vjtag_sram_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: SRAM address width.
REQ-002 SHALL have parameter DATA_W, default 8: SRAM data width.
REQ-003 SHALL have parameter RD_LAT, default 1 (range 1-4): clk cycles from sram_re to valid sram_rdata.
REQ-004 SHALL have port clk, input, 1: sole clock; all logic is on rising edges.
REQ-005 SHALL have port aclr_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have ports tck, tdi, v_sdr, udr, each input, 1: virtual-JTAG strobes, asynchronous to clk.
REQ-007 SHALL have port tdo, output, 1: serial readback.
REQ-008 SHALL have ports sram_addr output ADDR_W, sram_wdata output DATA_W, sram_rdata input DATA_W: SRAM address, write data and read data.
REQ-009 SHALL have ports sram_we output 1, sram_re output 1: single-cycle SRAM strobes.
REQ-010 SHALL have ports busy output 1 (command in progress) and cmd_drop output 1 (one-cycle pulse: command discarded).

Function
REQ-011 tck, tdi, v_sdr and udr SHALL each pass a 2-flop synchroniser; tck and udr rising edges are detected on synchronised values.
REQ-012 Frame register SHALL be FW = 2+ADDR_W+DATA_W bits: on each synchronised tck rise with v_sdr=1, shift right, tdi into bit FW-1, tdo = bit 0.
REQ-013 Frame fields SHALL be [1:0] opcode, [DATA_W+1:2] data, [FW-1:DATA_W+2] address; opcodes: 00 NOP, 01 WRITE, 10 READ, 11 SETADDR.
REQ-014 FSM states SHALL be IDLE, WR, RD_WAIT and RD_DONE; busy=1 in every state except IDLE.
REQ-015 On udr rise in IDLE, fields SHALL latch; WRITE -> WR, READ -> RD_WAIT, NOP/SETADDR -> remain IDLE.
REQ-016 The cycle after the detected udr rise, WR SHALL drive sram_we=1 for exactly one cycle with sram_addr/sram_wdata valid, then return to IDLE.
REQ-017 RD_WAIT SHALL pulse sram_re for one cycle, then hold for RD_LAT cycles, sample sram_rdata, and enter RD_DONE.
REQ-018 RD_DONE SHALL load the read data into frame bits [DATA_W-1:0] once v_sdr=0, then return to IDLE; while v_sdr=1 it SHALL wait.
REQ-019 A udr rise while busy=1 SHALL discard the command and pulse cmd_drop for one cycle; the FSM is unaffected.
REQ-020 sram_we and sram_re SHALL never both be 1, and SHALL be 0 outside WR and the first RD_WAIT cycle.
REQ-021 Tck edges SHALL continue to shift the frame during any FSM state.

Reset
REQ-022 On aclr_n=0, all of the following SHALL clear to 0 immediately: FSM state (to IDLE), frame register, address pointer, synchroniser flops, tdo, sram_we, sram_re, sram_addr, sram_wdata, busy and cmd_drop.
REQ-023 Reset mid-write or mid-read SHALL abort with no further strobe after release; release is synchronised by the instantiating level.

Configuration
REQ-024 With AUTO_INC_EN defined, SETADDR SHALL load an internal pointer from the address field, and WRITE/READ SHALL use the pointer (ignoring the address field) and increment it by 1 after the strobe, wrapping from 2^ADDR_W-1 to 0.
REQ-025 Without AUTO_INC_EN, WRITE/READ SHALL use the frame address field, SETADDR SHALL behave as NOP, and no pointer register SHALL exist.

Structure
REQ-026 Package vjtag_pkg SHALL hold the opcode enum, the FSM state enum and the localparam function for FW.
REQ-027 Sub-module vjtag_sync SHALL be a parametrised-width 2-flop synchroniser plus rising-edge detector, reset by aclr_n.

Verification
REQ-028 Shift WRITE addr=0x1234 data=0xA5, pulse udr -> one sram_we pulse, sram_addr=0x1234, sram_wdata=0xA5, busy high 1 cycle.
REQ-029 Preload SRAM 0x0010=0x3C; READ 0x0010 with RD_LAT=2 -> sram_re 1 cycle, next shift-out first 8 tdo bits (LSB first) = 0x3C.
REQ-030 AUTO_INC_EN: SETADDR 0xFFFF, then WRITE 0x11 and WRITE 0x22 -> writes land at 0xFFFF then 0x0000.
REQ-031 Second udr during RD_WAIT (RD_LAT=4) -> cmd_drop one pulse, exactly one sram_re, no sram_we.
REQ-032 aclr_n low during RD_WAIT -> all outputs 0 at once, no sram_re or sram_we after release, next WRITE works normally.
